collision_scan_ctrl: RTL and testbench

Sequencer for the frog-vs-obstacle collision check in the game's collision path. On a start pulse it fetches the obstacle row word for the frog's lane from lane memory and registers it. It then steps an 8:1 bit mux through all eight columns, MSB (column 0) first. It reports whether any obstacle bit overlaps the frog's footprint, the first overlapping column, and the overlap count, all with fixed latency.

---
 rtl/collision_scan_ctrl_pkg.sv | 18 +
 rtl/collision_scan_ctrl_mux.sv | 11 +
 rtl/collision_scan_ctrl.sv | 112 +++++++++++
 tb/tb_collision_scan_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/collision_scan_ctrl_pkg.sv
// Shared definitions for the frog-vs-obstacle collision scan: state encoding,
// row width and scan-select width.
package collision_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    SCAN  = 3'd3,
    DONE  = 3'd4
  } scan_state_t;

  localparam int COLS      = 8;
  localparam int SEL_WIDTH = 3;

  localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(COLS - 1);

endpackage

// File: rtl/collision_scan_ctrl_mux.sv
// 8:1 bit mux over an obstacle row word; select 0 is the leftmost column
// (bit 7), select 7 the rightmost (bit 0).
module Muxx81X (
  input  logic [7:0] data_in,
  input  logic [2:0] sel,
  output logic       bit_out
);

  assign bit_out = data_in[3'd7 - sel];

endmodule

// File: rtl/collision_scan_ctrl.sv
// Collision scan sequencer: fetches the frog's lane row, walks its eight
// columns through the bit mux and accumulates overlap with the frog footprint.
module collision_scan_ctrl
  import collision_scan_ctrl_pkg::*;
#(
  parameter int FROG_WIDTH     = 2,
  parameter int ROW_ADDR_WIDTH = 3
) (
  input  logic                      CollisionScan_CLOCK_50,
  input  logic                      CollisionScan_RESET_InHigh,
  input  logic                      CollisionScan_Start_In,
  input  logic [ROW_ADDR_WIDTH-1:0] CollisionScan_FrogRow_In,
  input  logic [2:0]                CollisionScan_FrogCol_In,
  output logic [ROW_ADDR_WIDTH-1:0] CollisionScan_RowAddr_Out,
  input  logic [7:0]                CollisionScan_RowData_In,
  output logic                      CollisionScan_Busy_Out,
  output logic                      CollisionScan_Done_Out,
  output logic                      CollisionScan_Collision_Out,
  output logic [2:0]                CollisionScan_HitCol_Out,
  output logic [1:0]                CollisionScan_HitCount_Out
);

  scan_state_t               state_q, state_d;
  logic [ROW_ADDR_WIDTH-1:0] row_addr;
  logic [2:0]                frog_col;
  logic [COLS-1:0]           row_reg;
  logic [SEL_WIDTH-1:0]      sel;
  logic                      collision;
  logic [2:0]                hit_col;
  logic [1:0]                hit_count;
  logic                      scan_bit;
  logic                      in_footprint;
  logic [3:0]                fp_lo, fp_hi, sel_ext;

  Muxx81X u_mux (
    .data_in (row_reg),
    .sel     (sel),
    .bit_out (scan_bit)
  );

  // Footprint bounds are widened to 4 bits so a footprint running past
  // column 7 simply stops there instead of wrapping back to column 0.
  assign sel_ext      = {1'b0, sel};
  assign fp_lo        = {1'b0, frog_col};
  assign fp_hi        = fp_lo + 4'(FROG_WIDTH - 1);
  assign in_footprint = (sel_ext >= fp_lo) && (sel_ext <= fp_hi);

  always_ff @(posedge CollisionScan_CLOCK_50 or posedge CollisionScan_RESET_InHigh) begin
    if (CollisionScan_RESET_InHigh) state_q <= IDLE;
    else                            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (CollisionScan_Start_In) state_d = FETCH;
      FETCH:   state_d = LATCH;
      LATCH:   state_d = SCAN;
      SCAN:    if (sel == LAST_SEL) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Only the first overlapping column is recorded; later hits just count.
  always_ff @(posedge CollisionScan_CLOCK_50 or posedge CollisionScan_RESET_InHigh) begin
    if (CollisionScan_RESET_InHigh) begin
      row_addr  <= '0;
      frog_col  <= '0;
      row_reg   <= '0;
      sel       <= '0;
      collision <= 1'b0;
      hit_col   <= '0;
      hit_count <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (CollisionScan_Start_In) begin
            row_addr  <= CollisionScan_FrogRow_In;
            frog_col  <= CollisionScan_FrogCol_In;
            collision <= 1'b0;
            hit_col   <= '0;
            hit_count <= '0;
          end
        end
        LATCH: begin
          row_reg <= CollisionScan_RowData_In;
          sel     <= '0;
        end
        SCAN: begin
          if (in_footprint && scan_bit) begin
            hit_count <= hit_count + 2'd1;
            if (!collision) begin
              collision <= 1'b1;
              hit_col   <= sel;
            end
          end
          if (sel != LAST_SEL) sel <= sel + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign CollisionScan_RowAddr_Out   = row_addr;
  assign CollisionScan_Busy_Out      = (state_q != IDLE);
  assign CollisionScan_Done_Out      = (state_q == DONE);
  assign CollisionScan_Collision_Out = collision;
  assign CollisionScan_HitCol_Out    = hit_col;
  assign CollisionScan_HitCount_Out  = hit_count;

endmodule

// File: tb/tb_collision_scan_ctrl.sv
// Directed bench for collision_scan_ctrl: a 2-wide and a 3-wide frog scanner
// share stimulus, each fed by its own one-cycle-latency lane memory model.
module tb_collision_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] frog_row;
  logic [2:0] frog_col;
  logic [7:0] lane_mem [8];

  logic [2:0] row_addr_a, row_addr_b;
  logic [7:0] row_data_a, row_data_b;
  logic       busy_a, busy_b, done_a, done_b, coll_a, coll_b;
  logic [2:0] hit_col_a, hit_col_b;
  logic [1:0] hit_count_a, hit_count_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    row_data_a <= lane_mem[row_addr_a];
    row_data_b <= lane_mem[row_addr_b];
  end

  collision_scan_ctrl #(.FROG_WIDTH(2), .ROW_ADDR_WIDTH(3)) dut (
    .CollisionScan_CLOCK_50      (clk),
    .CollisionScan_RESET_InHigh  (rst),
    .CollisionScan_Start_In      (start),
    .CollisionScan_FrogRow_In    (frog_row),
    .CollisionScan_FrogCol_In    (frog_col),
    .CollisionScan_RowAddr_Out   (row_addr_a),
    .CollisionScan_RowData_In    (row_data_a),
    .CollisionScan_Busy_Out      (busy_a),
    .CollisionScan_Done_Out      (done_a),
    .CollisionScan_Collision_Out (coll_a),
    .CollisionScan_HitCol_Out    (hit_col_a),
    .CollisionScan_HitCount_Out  (hit_count_a)
  );

  collision_scan_ctrl #(.FROG_WIDTH(3), .ROW_ADDR_WIDTH(3)) dut_w3 (
    .CollisionScan_CLOCK_50      (clk),
    .CollisionScan_RESET_InHigh  (rst),
    .CollisionScan_Start_In      (start),
    .CollisionScan_FrogRow_In    (frog_row),
    .CollisionScan_FrogCol_In    (frog_col),
    .CollisionScan_RowAddr_Out   (row_addr_b),
    .CollisionScan_RowData_In    (row_data_b),
    .CollisionScan_Busy_Out      (busy_b),
    .CollisionScan_Done_Out      (done_b),
    .CollisionScan_Collision_Out (coll_b),
    .CollisionScan_HitCol_Out    (hit_col_b),
    .CollisionScan_HitCount_Out  (hit_count_b)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulses Start for one cycle, then waits (bounded) for Done; lat is the
  // number of rising edges from the accepting edge up to the Done cycle.
  task automatic apply_stimulus(input logic [7:0] row, input logic [2:0] lane,
                                input logic [2:0] col, output int lat);
    lane_mem[lane] = row;
    @(negedge clk);
    start    = 1'b1;
    frog_row = lane;
    frog_col = col;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done_a && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic scan_and_check(input string name, input logic [7:0] row,
                                input logic [2:0] lane, input logic [2:0] col,
                                input bit wide, input logic exp_coll,
                                input logic [2:0] exp_col, input logic [1:0] exp_cnt);
    int lat;
    apply_stimulus(row, lane, col, lat);
    check_output({name, ".latency"}, lat, 11);
    check_output({name, ".busy_at_done"}, busy_a, 1'b1);
    check_output({name, ".row_addr"}, row_addr_a, lane);
    check_output({name, ".collision"}, wide ? coll_b : coll_a, exp_coll);
    check_output({name, ".hit_col"}, wide ? hit_col_b : hit_col_a, exp_col);
    check_output({name, ".hit_count"}, wide ? hit_count_b : hit_count_a, exp_cnt);
    @(negedge clk);
    check_output({name, ".done_pulse_end"}, done_a, 1'b0);
    check_output({name, ".busy_end"}, busy_a, 1'b0);
    repeat (3) @(negedge clk);
    check_output({name, ".hold_collision"}, wide ? coll_b : coll_a, exp_coll);
    check_output({name, ".hold_count"}, wide ? hit_count_b : hit_count_a, exp_cnt);
  endtask

  initial begin
    int dones;
    for (int i = 0; i < 8; i++) lane_mem[i] = 8'h00;
    rst      = 1'b1;
    start    = 1'b0;
    frog_row = 3'd0;
    frog_col = 3'd0;
    #12;
    check_output("reset.row_addr", row_addr_a, 3'd0);
    check_output("reset.busy", busy_a, 1'b0);
    check_output("reset.done", done_a, 1'b0);
    check_output("reset.collision", coll_a, 1'b0);
    check_output("reset.hit_col", hit_col_a, 3'd0);
    check_output("reset.hit_count", hit_count_a, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed scans");
    scan_and_check("single_hit", 8'b0001_0000, 3'd2, 3'd3, 1'b0, 1'b1, 3'd3, 2'd1);
    scan_and_check("full_w3", 8'hFF, 3'd4, 3'd2, 1'b1, 1'b1, 3'd2, 2'd3);
    scan_and_check("full_w2", 8'hFF, 3'd4, 3'd2, 1'b0, 1'b1, 3'd2, 2'd2);
    scan_and_check("empty_row", 8'h00, 3'd6, 3'd4, 1'b0, 1'b0, 3'd0, 2'd0);
    scan_and_check("edge_hit", 8'b0000_0001, 3'd3, 3'd7, 1'b0, 1'b1, 3'd7, 2'd1);
    scan_and_check("no_wrap", 8'b1000_0000, 3'd7, 3'd7, 1'b0, 1'b0, 3'd0, 2'd0);
    scan_and_check("two_hits", 8'b0110_0000, 3'd1, 3'd1, 1'b0, 1'b1, 3'd1, 2'd2);

    $display("[TB] start re-pulsed during FETCH, SCAN and DONE");
    lane_mem[5] = 8'b0001_0000;
    lane_mem[2] = 8'hFF;
    dones = 0;
    @(negedge clk);
    start    = 1'b1;
    frog_row = 3'd5;
    frog_col = 3'd3;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (done_a) dones++;
      if (n == 2 || n == 6 || n == 12) check_output("repulse.row_addr", row_addr_a, 3'd5);
      if (n == 11) begin
        check_output("repulse.done_cycle", done_a, 1'b1);
        check_output("repulse.collision", coll_a, 1'b1);
        check_output("repulse.hit_col", hit_col_a, 3'd3);
        check_output("repulse.hit_count", hit_count_a, 2'd1);
      end
      if (n == 12 || n == 14) check_output("repulse.idle_after_done", busy_a, 1'b0);
      start    = (n == 1 || n == 5 || n == 11);
      frog_row = start ? 3'd2 : 3'd5;
      frog_col = start ? 3'd0 : 3'd3;
    end
    start = 1'b0;
    check_output("repulse.done_count", dones, 1);
    scan_and_check("after_repulse", 8'hFF, 3'd2, 3'd0, 1'b0, 1'b1, 3'd0, 2'd2);

    $display("[TB] reset during fourth SCAN cycle");
    lane_mem[1] = 8'hFF;
    @(negedge clk);
    start    = 1'b1;
    frog_row = 3'd1;
    frog_col = 3'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_output("pre_reset.hit_count", hit_count_a, 2'd2);
    rst = 1'b1;
    #1;
    check_output("midreset.row_addr", row_addr_a, 3'd0);
    check_output("midreset.busy", busy_a, 1'b0);
    check_output("midreset.done", done_a, 1'b0);
    check_output("midreset.collision", coll_a, 1'b0);
    check_output("midreset.hit_col", hit_col_a, 3'd0);
    check_output("midreset.hit_count", hit_count_a, 2'd0);
    @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    check_output("midreset.no_done", dones, 0);
    check_output("midreset.idle", busy_a, 1'b0);
    scan_and_check("after_reset", 8'b0000_1000, 3'd1, 3'd4, 1'b0, 1'b1, 3'd4, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
